ysyx_ifu: RTL
=============

// Module: ysyx_ifu
// PURPOSE
//  Parametrised instruction-fetch unit; replaces the bare PC register feeding the core
//  top. Issues sequential fetch requests to instruction memory over a valid/ready channel
//  and tolerates up to DEPTH requests in flight. Buffers returned words with their PC in
//  a FIFO and hands them to the IDU via valid/ready. On a redirect from the EXU (jump or
//  branch) it flushes the buffer and discards stale in-flight responses.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h8000_0000 first fetch address after reset
//  DEPTH     4             instruction FIFO entries = max (buffered + in-flight); power of 2, >=2
// PORTS
//  clk             in   1     clock, all state on posedge
//  rst             in   1     asynchronous, active-high reset
//  redirect_valid  in   1     EXU redirect strobe, one cycle
//  redirect_pc     in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address, word aligned
//  imem_rsp_valid  in   1     response valid; in order, no backpressure, >=1 cycle after accept
//  imem_rsp_data   in   32    fetched instruction word
//  inst_valid      out  1     FIFO head valid to IDU
//  inst_ready      in   1     IDU consumes head
//  inst            out  32    head instruction; 0 when empty
//  inst_pc         out  XLEN  head PC; 0 when empty
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty;
//    imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0 while rst is high.
//  - imem_req_addr = fetch_pc. imem_req_valid = (count + inflight < DEPTH) && !redirect_valid.
//    First request is presented in the first cycle after rst deasserts.
//  - Request accepted (valid&&ready): fetch_pc += 4, inflight += 1. While not accepted, addr
//    is held stable. Withdrawal happens only in a redirect cycle.
//  - Response: inflight -= 1 every rsp cycle. If drop_cnt>0, discard the word and decrement
//    drop_cnt. Otherwise write {rsp_pc, data} to FIFO and increment rsp_pc by 4.
//    Simultaneous accept+rsp leaves inflight unchanged.
//  - Credit rule (count+inflight<=DEPTH) guarantees no overflow; rsp is always accepted.
//  - Dequeue on inst_valid&&inst_ready; inst_valid = !empty && !redirect_valid.
//    Zero-latency bypass not provided: rsp->inst_valid latency is 1 cycle.
//  - Redirect cycle (highest priority): no request is issued; no dequeue occurs. FIFO is
//    cleared next edge. Any rsp this cycle is discarded.
//    drop_cnt <= inflight - (rsp this cycle ? 1:0) + (drop_cnt already pending excluded);
//    i.e. every request issued before redirect is dropped.
//    fetch_pc <= {redirect_pc[XLEN-1:2],2'b0}, rsp_pc <= the same aligned target.
//  - Back-to-back redirects: the last one wins; drop accounting stays exact.
//  - rsp_valid with inflight==0 is a protocol error: ignored, flagged by an assertion.
//  - PC arithmetic is modulo 2^XLEN; wraps from all-ones-minus-3 to 0 without special case.
//  - Steady state with imem latency 1 and inst_ready=1: one instruction per cycle.
// TESTING
//  1. Reset release, req_ready=1, rsp 1 cycle later, inst_ready=1 -> addrs 0x80000000,
//     0x80000004, 0x80000008...; inst_pc matches; 1 inst/cycle after 2-cycle fill.
//  2. inst_ready=0 -> exactly 4 requests issued, then req_valid=0. One pop -> exactly one
//     new request next cycle.
//  3. Redirect to 0x80001002 with 2 in flight -> next 2 rsps dropped; first inst_pc =
//     0x80001000; next req addr = 0x80001000.
//  4. Redirect coincident with rsp and inst_ready=1 on non-empty FIFO -> no dequeue,
//     rsp dropped, inst_valid=0 next cycle, drop_cnt = remaining inflight.
//  5. req_ready=0 for 5 cycles -> req_valid=1 and addr constant throughout; accepted on
//     the 6th cycle, then addr += 4.
//  6. Assert rst mid-burst between edges -> req_valid/inst_valid drop immediately.
//     After release, fetch restarts at 0x80000000; late rsps are ignored.

Source files
------------

// File: rtl/ysyx_ifu.sv
// Instruction-fetch unit: issues sequential word fetches with up to DEPTH requests in
// flight, buffers returned words with their PC, and flushes on an EXU redirect.
module ysyx_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    CW      = AW + 1;
  localparam logic [CW:0]    DEPTH_U = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, inflight_q, drop_cnt_q;

  logic            empty, req_fire, rsp_fire, rsp_keep, deq;
  logic [CW:0]     used;
  logic [XLEN-1:0] target_pc;
  entry_t          head;

  assign target_pc = redirect_pc & ~XLEN'(3);
  assign used      = {1'b0, count_q} + {1'b0, inflight_q};
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];

  // Credit covers buffered plus in-flight words, so a response always has a free slot.
  assign imem_req_valid = !rst && !redirect_valid && (used < DEPTH_U);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_fire && !redirect_valid && (drop_cnt_q == '0);

  assign inst_valid = !empty && !redirect_valid;
  assign deq        = inst_valid && inst_ready;
  assign inst       = empty ? 32'h0 : head.word;
  assign inst_pc    = empty ? '0 : head.pc;

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        // Everything still outstanding after this cycle's response was issued pre-redirect.
        fetch_pc_q <= target_pc;
        rsp_pc_q   <= target_pc;
        drop_cnt_q <= inflight_q - CW'(rsp_fire);
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CW'(1);
        if (rsp_keep) begin
          rsp_pc_q <= rsp_pc_q + XLEN'(4);
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(rsp_keep) - CW'(deq);
      end
    end
  end

  // NOTE: the entry storage has no reset; occupancy is tracked by count_q, and empty reads are masked.
  always_ff @(posedge clk) begin
    if (rsp_keep) mem_q[wr_ptr_q] <= '{pc: rsp_pc_q, word: imem_rsp_data};
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) assert (inflight_q != '0);
  end

endmodule
